vga_timing_controller: RTL and testbench
========================================

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 Parameter CLK_DIV, default 2: system clocks per pixel; legal range 1..16.
REQ-002 Parameters H_ACTIVE/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48: horizontal timing in pixels; H_TOTAL is their sum, 800 by default.
REQ-003 Parameters V_ACTIVE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33: vertical timing in lines; V_TOTAL is their sum, 525 by default.
REQ-004 Parameter SYNC_POL, default 0: asserted level of hsync/vsync; 0 means active-low.
REQ-005 Port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port enable, input, 1 bit: request to run the raster.
REQ-008 Port pix_tick, output, 1 bit: one-clk pixel strobe for the downstream pixel datapath.
REQ-009 Ports hsync and vsync, outputs, 1 bit each: sync pulses for the monitor.
REQ-010 Port video_on, output, 1 bit: current pixel is in the visible area.
REQ-011 Ports pixel_x and pixel_y, outputs, 10 bits each: visible pixel coordinates.
REQ-012 Ports line_start and frame_start, outputs, 1 bit each: one-clk markers.

Function
REQ-013 All outputs shall be registered; no combinational path from any input to any output.
REQ-014 Divider: counter div_cnt runs 0..CLK_DIV-1 while in RUN or STOP_PEND; pix_tick is high for the one clk where div_cnt==CLK_DIV-1; with CLK_DIV=1, pix_tick is constant high in RUN.
REQ-015 h_cnt shall advance only on a pix_tick and wrap H_TOTAL-1 -> 0.
REQ-016 v_cnt shall advance only on the h_cnt wrap and wrap V_TOTAL-1 -> 0.
REQ-017 hsync shall be at the SYNC_POL level iff H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
REQ-018 vsync shall be at the SYNC_POL level iff V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC.
REQ-019 video_on shall be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, and the state is not IDLE.
REQ-020 pixel_x and pixel_y shall equal h_cnt and v_cnt when video_on=1; otherwise both are 0.
REQ-021 line_start shall be high for exactly one clk: the first clk with h_cnt==0 after h_cnt changes, or after leaving IDLE.
REQ-022 frame_start shall be high for exactly one clk: the first clk with h_cnt==0 and v_cnt==0 under the same conditions as line_start; it coincides with line_start.
REQ-023 The FSM shall have three states: IDLE, RUN and STOP_PEND.
REQ-024 IDLE: when enable=1, go to RUN on the next clk with counters at 0; the first pix_tick follows CLK_DIV clks later.
REQ-025 RUN: when enable=0, go to STOP_PEND; the raster continues unchanged.
REQ-026 STOP_PEND with enable=1 again: return to RUN with no timing disturbance.
REQ-027 STOP_PEND with enable still 0 at the (H_TOTAL-1, V_TOTAL-1) wrap tick: go to IDLE; frames are never truncated.
REQ-028 In IDLE: div_cnt, h_cnt and v_cnt are held at 0; hsync and vsync are inactive (~SYNC_POL); pix_tick, video_on, line_start and frame_start are 0; pixel_x and pixel_y are 0.
REQ-029 If enable pulses for a single clk in IDLE, the block shall go RUN then STOP_PEND and complete exactly one frame.

Reset
REQ-030 reset=1 at a rising edge shall force IDLE with the REQ-028 output values on the next clk, regardless of state or position in the frame; reset overrides enable.
REQ-031 On the clk after reset is released with enable=1, the state shall be RUN; behaviour is otherwise identical to REQ-024.

Verification
REQ-032 Reset, then enable held at 1 with defaults -> first pix_tick at clk 2 after RUN entry; frame_start and line_start high together; pixel (0,0) with video_on=1.
REQ-033 Horizontal timing -> hsync low exactly for h_cnt 656..751 (96 ticks = 192 clks); video_on low for h_cnt 640..799; line_start period 1600 clks.
REQ-034 Vertical timing -> vsync low for v_cnt 490..491 only; frame_start period 840000 clks; pixel_y maximum 479; pixel_x maximum 639.
REQ-035 enable dropped at v_cnt=100 -> frame completes to (799,524); IDLE on the next tick; outputs per REQ-028; re-enable within STOP_PEND produces no gap in frame_start.
REQ-036 reset asserted at h_cnt=300, v_cnt=200 -> next clk in IDLE with hsync=vsync=1 and video_on=0; after release, counting restarts from (0,0).
REQ-037 CLK_DIV=1 and SYNC_POL=1 -> pix_tick constant high in RUN; hsync high for h_cnt 656..751; frame period 420000 clks.

Source files
------------

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters, sync pulses, visible-area flag and line/frame markers.
// Stopping is deferred to the end of the current frame so the monitor never
// sees a truncated frame.
//
// Handshake: there is no valid/ready pair here. `enable` is a level request;
// it is sampled every clk, and a drop only takes effect at the last pixel of
// the frame (the raster keeps running in STOP_PEND until then).
//
// All outputs, including state_dbg, come straight from flops. Each output flop
// is loaded from the *next* counter/state values, so an output always
// describes the counters' current values in the same clk.
module vga_timing_controller #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [1:0] state_dbg
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);
  localparam logic       SYNC_OFF = !SYNC_ACT;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  logic       tick;
  logic       frame_end;

  logic       pix_tick_q, pix_tick_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       active_d;

  // Next state and next raster position: divider, h wrap, v wrap, deferred stop.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    tick      = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
    frame_end = tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    if (state_q != IDLE) begin
      if (tick) begin
        div_cnt_d = '0;
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end else begin
          h_cnt_d = h_cnt_q + 10'd1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        h_cnt_d   = '0;
        v_cnt_d   = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = STOP_PEND;
      end
      STOP_PEND: begin
        if (enable)         state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values describing the next raster position, loaded into output flops.
  always_comb begin
    active_d      = (state_d != IDLE);
    pix_tick_d    = active_d && (div_cnt_d == DIV_LAST);
    hsync_d       = (active_d && (h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? SYNC_ACT : SYNC_OFF;
    vsync_d       = (active_d && (v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? SYNC_ACT : SYNC_OFF;
    video_on_d    = active_d && (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    pixel_x_d     = video_on_d ? h_cnt_d : 10'd0;
    pixel_y_d     = video_on_d ? v_cnt_d : 10'd0;
    // h_cnt only lands on 0 by wrapping or by leaving IDLE; mark that first clk.
    line_start_d  = active_d && (h_cnt_d == 10'd0) && ((state_q == IDLE) || (h_cnt_q != 10'd0));
    frame_start_d = line_start_d && (v_cnt_d == 10'd0);
  end

  // State, counters and output registers with synchronous reset to IDLE values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_tick_q    <= 1'b0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_tick_q    <= pix_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller using a reduced raster so whole
// frames fit in a short run:
//   H 8/2/3/2 (total 15, hsync at h 10..12), V 4/1/2/1 (total 8, vsync at v 5..6).
// dut0: CLK_DIV=2, SYNC_POL=0 (frame 240 clks, line 30 clks).
// dut1: CLK_DIV=1, SYNC_POL=1 (frame 120 clks).
// r counts negedges after the posedge where both DUTs enter RUN (r=0 is the
// first RUN clk). With CLK_DIV=2 the pixel index at r is r/2; with CLK_DIV=1 it is r.
module tb_vga_timing_controller;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  always #5 clk = ~clk;

  logic       pix_tick0, hsync0, vsync0, video_on0, line_start0, frame_start0;
  logic [9:0] pixel_x0, pixel_y0;
  logic [1:0] state0;
  logic       pix_tick1, hsync1, vsync1, video_on1, line_start1, frame_start1;
  logic [9:0] pixel_x1, pixel_y1;
  logic [1:0] state1;

  vga_timing_controller #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(0)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(en0),
    .pix_tick(pix_tick0), .hsync(hsync0), .vsync(vsync0), .video_on(video_on0),
    .pixel_x(pixel_x0), .pixel_y(pixel_y0),
    .line_start(line_start0), .frame_start(frame_start0), .state_dbg(state0)
  );

  vga_timing_controller #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(en1),
    .pix_tick(pix_tick1), .hsync(hsync1), .vsync(vsync1), .video_on(video_on1),
    .pixel_x(pixel_x1), .pixel_y(pixel_y1),
    .line_start(line_start1), .frame_start(frame_start1), .state_dbg(state1)
  );

  // Scoreboard counters
  int n_cmp = 0;
  int n_err = 0;
  int rc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Driver: advance to negedge number r of the run.
  task automatic goto(input int r);
    while (rc < r) begin
      @(negedge clk);
      rc++;
    end
  endtask

  // Period/pulse monitors, sampled on the falling edge.
  int mcyc = 0;
  int fs0_cnt = 0, fs0_last = 0, fs0_period = 0;
  bit fs0_seen = 1'b0;
  int ls0_last = 0, ls0_period = 0;
  bit ls0_seen = 1'b0;
  int hs0_run = 0, hs0_len = 0;
  int max_x0 = 0, max_y0 = 0;
  int fs1_last = 0, fs1_period = 0;
  bit fs1_seen = 1'b0;
  int hs1_run = 0, hs1_len = 0;
  int pt1_low = 0;

  always @(negedge clk) begin
    mcyc <= mcyc + 1;
    if (frame_start0) begin
      fs0_cnt  <= fs0_cnt + 1;
      if (fs0_seen) fs0_period <= mcyc - fs0_last;
      fs0_last <= mcyc;
      fs0_seen <= 1'b1;
    end
    if (line_start0) begin
      if (ls0_seen) ls0_period <= mcyc - ls0_last;
      ls0_last <= mcyc;
      ls0_seen <= 1'b1;
    end
    if (!hsync0 && state0 != S_IDLE) hs0_run <= hs0_run + 1;
    else begin
      if (hs0_run != 0) hs0_len <= hs0_run;
      hs0_run <= 0;
    end
    if (video_on0 && int'(pixel_x0) > max_x0) max_x0 <= int'(pixel_x0);
    if (video_on0 && int'(pixel_y0) > max_y0) max_y0 <= int'(pixel_y0);
    if (frame_start1) begin
      if (fs1_seen) fs1_period <= mcyc - fs1_last;
      fs1_last <= mcyc;
      fs1_seen <= 1'b1;
    end
    if (hsync1) hs1_run <= hs1_run + 1;
    else begin
      if (hs1_run != 0) hs1_len <= hs1_run;
      hs1_run <= 0;
    end
    if (state1 != S_IDLE && !pix_tick1) pt1_low <= pt1_low + 1;
  end

  // Directed sequence
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state0", state0, S_IDLE);
    chk("rst_hsync0", hsync0, 1);
    chk("rst_vsync0", vsync0, 1);
    chk("rst_video0", video_on0, 0);
    chk("rst_tick0", pix_tick0, 0);
    chk("rst_ls0", line_start0, 0);
    chk("rst_fs0", frame_start0, 0);
    chk("rst_px0", pixel_x0, 0);
    chk("rst_hsync1", hsync1, 0);
    chk("rst_vsync1", vsync1, 0);

    reset = 1'b0; en0 = 1'b1; en1 = 1'b1;
    @(negedge clk);
    rc = 0;
    chk("r0_state0", state0, S_RUN);
    chk("r0_tick0", pix_tick0, 0);
    chk("r0_ls0", line_start0, 1);
    chk("r0_fs0", frame_start0, 1);
    chk("r0_video0", video_on0, 1);
    chk("r0_px0", pixel_x0, 0);
    chk("r0_py0", pixel_y0, 0);
    chk("r0_tick1", pix_tick1, 1);
    chk("r0_fs1", frame_start1, 1);

    goto(1);
    chk("r1_tick0", pix_tick0, 1);
    chk("r1_fs0", frame_start0, 0);
    chk("r1_ls0", line_start0, 0);
    chk("r1_px0", pixel_x0, 0);
    goto(2);
    chk("r2_px0", pixel_x0, 1);
    chk("r2_tick0", pix_tick0, 0);

    goto(9);
    chk("h9_hsync1", hsync1, 0);
    goto(10);
    chk("h10_hsync1", hsync1, 1);
    goto(12);
    chk("h12_hsync1", hsync1, 1);
    goto(13);
    chk("h13_hsync1", hsync1, 0);

    goto(19);
    chk("h9_hsync0", hsync0, 1);
    chk("h9_video0", video_on0, 0);
    chk("h9_px0", pixel_x0, 0);
    chk("p19_px1", pixel_x1, 4);
    chk("p19_py1", pixel_y1, 1);
    goto(20);
    chk("h10_hsync0", hsync0, 0);
    goto(25);
    chk("h12_hsync0", hsync0, 0);
    goto(26);
    chk("h13_hsync0", hsync0, 1);

    goto(30);
    chk("l1_ls0", line_start0, 1);
    chk("l1_fs0", frame_start0, 0);
    chk("l1_py0", pixel_y0, 1);
    chk("l1_video0", video_on0, 1);
    goto(31);
    chk("l1b_ls0", line_start0, 0);

    goto(100);
    chk("line_period0", ls0_period, 30);
    chk("hsync_len0", hs0_len, 6);
    chk("p50_px0", pixel_x0, 5);
    chk("p50_py0", pixel_y0, 3);

    goto(149);
    chk("v4_vsync0", vsync0, 1);
    goto(150);
    chk("v5_vsync0", vsync0, 0);
    chk("v5_video0", video_on0, 0);
    chk("v5_py0", pixel_y0, 0);

    goto(200);
    en0 = 1'b0;
    goto(201);
    chk("stop_state0", state0, S_STOP);
    chk("stop_vsync0", vsync0, 0);
    chk("stop_hsync0", hsync0, 0);
    goto(209);
    chk("v6_vsync0", vsync0, 0);
    goto(210);
    chk("v7_vsync0", vsync0, 1);
    goto(230);
    en0 = 1'b1;
    goto(231);
    chk("rearm_state0", state0, S_RUN);
    goto(239);
    chk("last_tick0", pix_tick0, 1);
    chk("last_fs0", frame_start0, 0);
    goto(240);
    chk("f1_fs0", frame_start0, 1);
    chk("f1_ls0", line_start0, 1);
    chk("f1_video0", video_on0, 1);
    chk("f1_fs1", frame_start1, 1);
    goto(250);
    chk("frame_period0", fs0_period, 240);
    chk("frame_period1", fs1_period, 120);

    goto(300);
    en0 = 1'b0;
    goto(301);
    chk("stop2_state0", state0, S_STOP);
    chk("stop2_py0", pixel_y0, 2);
    chk("stop2_video0", video_on0, 1);
    goto(479);
    chk("end_state0", state0, S_STOP);
    chk("end_tick0", pix_tick0, 1);
    chk("end_hsync0", hsync0, 1);
    chk("end_vsync0", vsync0, 1);
    goto(480);
    chk("idle_state0", state0, S_IDLE);
    chk("idle_tick0", pix_tick0, 0);
    chk("idle_fs0", frame_start0, 0);
    chk("idle_ls0", line_start0, 0);
    chk("idle_video0", video_on0, 0);
    chk("idle_hsync0", hsync0, 1);
    chk("idle_vsync0", vsync0, 1);
    chk("idle_px0", pixel_x0, 0);
    chk("idle_py0", pixel_y0, 0);
    goto(485);
    chk("idle_hold0", state0, S_IDLE);

    goto(490);
    en0 = 1'b1;
    goto(491);
    chk("pulse_state0", state0, S_RUN);
    chk("pulse_fs0", frame_start0, 1);
    en0 = 1'b0;
    goto(492);
    chk("pulse_stop0", state0, S_STOP);
    goto(730);
    chk("pulse_end0", state0, S_STOP);
    chk("pulse_tick0", pix_tick0, 1);
    goto(731);
    chk("pulse_idle0", state0, S_IDLE);

    goto(740);
    chk("fs_count0", fs0_cnt, 3);
    chk("max_x0", max_x0, 7);
    chk("max_y0", max_y0, 3);
    chk("tick_const1", pt1_low, 0);
    chk("hsync_len1", hs1_len, 3);

    goto(800);
    chk("p80_vsync1", vsync1, 1);
    chk("p80_state1", state1, S_RUN);
    reset = 1'b1;
    goto(801);
    chk("mrst_state1", state1, S_IDLE);
    chk("mrst_hsync1", hsync1, 0);
    chk("mrst_vsync1", vsync1, 0);
    chk("mrst_video1", video_on1, 0);
    chk("mrst_tick1", pix_tick1, 0);
    reset = 1'b0;
    goto(802);
    chk("rel_state1", state1, S_RUN);
    chk("rel_fs1", frame_start1, 1);
    chk("rel_video1", video_on1, 1);
    chk("rel_px1", pixel_x1, 0);
    chk("rel_py1", pixel_y1, 0);
    goto(803);
    chk("rel2_px1", pixel_x1, 1);
    chk("rel2_fs1", frame_start1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
